// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (types only).
// Backpressure: n/a.
package hazard_pkg;

   // wb_sel encodings of the instruction in E
   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;   // result comes from data memory (load)
   localparam logic [1:0] WB_PC4 = 2'b10;
   localparam logic [1:0] WB_IMM = 2'b11;

   // Longest branch-dependency stall; sizes the stall down-counter
   localparam int MAX_BR_WAIT = 2;
   localparam int CNT_W       = $clog2(MAX_BR_WAIT + 1);

   typedef enum logic [1:0] {
      S_RUN     = 2'd0,
      S_LDUSE   = 2'd1,
      S_BRWAIT  = 2'd2,
      S_MEMWAIT = 2'd3
   } state_e;

   // The seven per-stage stall/flush strobes
   typedef struct packed {
      logic stall_f;
      logic stall_d;
      logic flush_d;
      logic flush_e;
      logic stall_e;
      logic stall_m;
      logic flush_w;
   } hz_ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard terms between D and the producers in E and M.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; consumed by hazard_ctrl.
// Ports: D-stage source regs/uses/branch flag, E and M destination info in;
//        ld_E, alu_E_br, dep_M_br out.
module hazard_detect
   import hazard_pkg::*;
(
   input  logic [4:0] rs1_addr_D,
   input  logic [4:0] rs2_addr_D,
   input  logic       rs1_used_D,
   input  logic       rs2_used_D,
   input  logic       is_branch_D,
   input  logic [4:0] rd_addr_E,
   input  logic       rd_wren_E,
   input  logic [1:0] wb_sel_E,
   input  logic [4:0] rd_addr_M,
   input  logic       rd_wren_M,
   output logic       ld_E,
   output logic       alu_E_br,
   output logic       dep_M_br
);

   logic match_E;
   logic match_M;

   // x0 is hard-wired zero, so it never creates a dependency; an rs1 and rs2
   // hit on the same producer collapses into one hazard.
   assign match_E = (rd_addr_E != 5'd0) &&
                    ((rs1_used_D && (rs1_addr_D == rd_addr_E)) ||
                     (rs2_used_D && (rs2_addr_D == rd_addr_E)));
   assign match_M = (rd_addr_M != 5'd0) &&
                    ((rs1_used_D && (rs1_addr_D == rd_addr_M)) ||
                     (rs2_used_D && (rs2_addr_D == rd_addr_M)));

   assign ld_E     = rd_wren_E && (wb_sel_E == WB_MEM) && match_E;
   // Covered by D-stage branch forwarding; reported but never stalls.
   assign alu_E_br = is_branch_D && rd_wren_E && !ld_E && match_E;
   assign dep_M_br = is_branch_D && rd_wren_M && match_M;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline (F, D, E, M, W).
// Latency: strobes are Mealy (same cycle as the hazard); multi-cycle stalls
//          are sequenced by the FSM and a down-counter.
// Backpressure: i_mem_busy_M freezes F..M and bubbles W; the FSM state and
//          counter are saved on entry and restored when the wait ends.
// Ports: D/E/M hazard info, redirect and mem-busy in; per-stage stall/flush
//        strobes and o_state out.
// Optional: define HAZARD_PERF_CNT_EN to add o_cnt_ldstall, o_cnt_brstall
//           and o_cnt_memstall saturating stall-cycle counters.
module hazard_ctrl
   import hazard_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [4:0] i_rs1_addr_D,
   input  logic [4:0] i_rs2_addr_D,
   input  logic       i_rs1_used_D,
   input  logic       i_rs2_used_D,
   input  logic       i_is_branch_D,
   input  logic [4:0] i_rd_addr_E,
   input  logic       i_rd_wren_E,
   input  logic [1:0] i_wb_sel_E,
   input  logic [4:0] i_rd_addr_M,
   input  logic       i_rd_wren_M,
   input  logic       i_redirect_E,
   input  logic       i_mem_busy_M,
   output logic       o_stall_F,
   output logic       o_stall_D,
   output logic       o_flush_D,
   output logic       o_flush_E,
   output logic       o_stall_E,
   output logic       o_stall_M,
   output logic       o_flush_W,
`ifdef HAZARD_PERF_CNT_EN
   output logic [31:0] o_cnt_ldstall,
   output logic [31:0] o_cnt_brstall,
   output logic [31:0] o_cnt_memstall,
`endif
   output logic [1:0] o_state
);

   logic ld_E, alu_E_br, dep_M_br;

   hazard_detect u_detect (
      .rs1_addr_D  (i_rs1_addr_D),
      .rs2_addr_D  (i_rs2_addr_D),
      .rs1_used_D  (i_rs1_used_D),
      .rs2_used_D  (i_rs2_used_D),
      .is_branch_D (i_is_branch_D),
      .rd_addr_E   (i_rd_addr_E),
      .rd_wren_E   (i_rd_wren_E),
      .wb_sel_E    (i_wb_sel_E),
      .rd_addr_M   (i_rd_addr_M),
      .rd_wren_M   (i_rd_wren_M),
      .ld_E        (ld_E),
      .alu_E_br    (alu_E_br),
      .dep_M_br    (dep_M_br)
   );

   // ALU->branch in E is resolved by forwarding; kept for visibility only.
   logic unused_alu_e_br;
   assign unused_alu_e_br = alu_E_br;

   state_e            state_q, sav_state_q, state_d, eff_state;
   logic [CNT_W-1:0]  cnt_q, sav_cnt_q, cnt_d, eff_cnt;
   hz_ctrl_t          ctrl;
   logic              ld_cyc, br_cyc, mem_cyc;

   // The first cycle after busy drops still shows S_MEMWAIT, but it already
   // behaves as the saved state so no stall cycle is lost or added.
   assign eff_state = (state_q == S_MEMWAIT) ? sav_state_q : state_q;
   assign eff_cnt   = (state_q == S_MEMWAIT) ? sav_cnt_q   : cnt_q;

   always_comb begin
      ctrl    = '0;
      state_d = eff_state;
      cnt_d   = eff_cnt;
      ld_cyc  = 1'b0;
      br_cyc  = 1'b0;
      mem_cyc = 1'b0;
      if (i_rst) begin
         ctrl.flush_d = 1'b1;
         ctrl.flush_e = 1'b1;
         state_d      = S_RUN;
         cnt_d        = '0;
      end else if (i_mem_busy_M) begin
         // A redirect here is ignored: E/M holds and re-presents it later.
         ctrl.stall_f = 1'b1;
         ctrl.stall_d = 1'b1;
         ctrl.stall_e = 1'b1;
         ctrl.stall_m = 1'b1;
         ctrl.flush_w = 1'b1;
         state_d      = S_MEMWAIT;
         mem_cyc      = 1'b1;
      end else if (i_redirect_E) begin
         // Squashes the stalled instruction, so any pending stall is dropped.
         ctrl.flush_d = 1'b1;
         ctrl.flush_e = 1'b1;
         state_d      = S_RUN;
         cnt_d        = '0;
      end else begin
         case (eff_state)
            S_LDUSE: state_d = S_RUN;
            S_BRWAIT: begin
               if (eff_cnt != '0) begin
                  ctrl.stall_f = 1'b1;
                  ctrl.stall_d = 1'b1;
                  ctrl.flush_e = 1'b1;
                  cnt_d        = eff_cnt - 1'b1;
                  br_cyc       = 1'b1;
               end else begin
                  state_d = S_RUN;
               end
            end
            default: begin
               if (ld_E || dep_M_br) begin
                  ctrl.stall_f = 1'b1;
                  ctrl.stall_d = 1'b1;
                  ctrl.flush_e = 1'b1;
               end
               // A branch behind a load needs the value one stage later than
               // an ALU op would, hence the longer wait.
               if (ld_E && !i_is_branch_D) begin
                  state_d = S_LDUSE;
                  cnt_d   = '0;
                  ld_cyc  = 1'b1;
               end else if (ld_E) begin
                  state_d = S_BRWAIT;
                  cnt_d   = CNT_W'(MAX_BR_WAIT - 1);
                  br_cyc  = 1'b1;
               end else if (dep_M_br) begin
                  state_d = S_BRWAIT;
                  cnt_d   = '0;
                  br_cyc  = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= S_RUN;
         cnt_q       <= '0;
         sav_state_q <= S_RUN;
         sav_cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (i_mem_busy_M) begin
            sav_state_q <= eff_state;
            sav_cnt_q   <= eff_cnt;
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] cnt_ld_q, cnt_br_q, cnt_mem_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_ld_q  <= '0;
         cnt_br_q  <= '0;
         cnt_mem_q <= '0;
      end else begin
         if (ld_cyc  && (cnt_ld_q  != 32'hFFFF_FFFF)) cnt_ld_q  <= cnt_ld_q  + 32'd1;
         if (br_cyc  && (cnt_br_q  != 32'hFFFF_FFFF)) cnt_br_q  <= cnt_br_q  + 32'd1;
         if (mem_cyc && (cnt_mem_q != 32'hFFFF_FFFF)) cnt_mem_q <= cnt_mem_q + 32'd1;
      end
   end

   assign o_cnt_ldstall  = cnt_ld_q;
   assign o_cnt_brstall  = cnt_br_q;
   assign o_cnt_memstall = cnt_mem_q;
`else
   logic unused_cause;
   assign unused_cause = ld_cyc | br_cyc | mem_cyc;
`endif

   assign o_stall_F = ctrl.stall_f;
   assign o_stall_D = ctrl.stall_d;
   assign o_flush_D = ctrl.flush_d;
   assign o_flush_E = ctrl.flush_e;
   assign o_stall_E = ctrl.stall_e;
   assign o_stall_M = ctrl.stall_m;
   assign o_flush_W = ctrl.flush_w;
   assign o_state   = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic [4:0] i_rs1_addr_D, i_rs2_addr_D;
   logic       i_rs1_used_D, i_rs2_used_D, i_is_branch_D;
   logic [4:0] i_rd_addr_E;
   logic       i_rd_wren_E;
   logic [1:0] i_wb_sel_E;
   logic [4:0] i_rd_addr_M;
   logic       i_rd_wren_M, i_redirect_E, i_mem_busy_M;
   logic       o_stall_F, o_stall_D, o_flush_D, o_flush_E, o_stall_E, o_stall_M, o_flush_W;
   logic [1:0] o_state;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] o_cnt_ldstall, o_cnt_brstall, o_cnt_memstall;
`endif

   hazard_ctrl dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_rs1_addr_D(i_rs1_addr_D), .i_rs2_addr_D(i_rs2_addr_D),
      .i_rs1_used_D(i_rs1_used_D), .i_rs2_used_D(i_rs2_used_D),
      .i_is_branch_D(i_is_branch_D),
      .i_rd_addr_E(i_rd_addr_E), .i_rd_wren_E(i_rd_wren_E), .i_wb_sel_E(i_wb_sel_E),
      .i_rd_addr_M(i_rd_addr_M), .i_rd_wren_M(i_rd_wren_M),
      .i_redirect_E(i_redirect_E), .i_mem_busy_M(i_mem_busy_M),
      .o_stall_F(o_stall_F), .o_stall_D(o_stall_D), .o_flush_D(o_flush_D),
      .o_flush_E(o_flush_E), .o_stall_E(o_stall_E), .o_stall_M(o_stall_M),
      .o_flush_W(o_flush_W),
`ifdef HAZARD_PERF_CNT_EN
      .o_cnt_ldstall(o_cnt_ldstall), .o_cnt_brstall(o_cnt_brstall),
      .o_cnt_memstall(o_cnt_memstall),
`endif
      .o_state(o_state)
   );

   always #5 i_clk = ~i_clk;

   // {stall_F, stall_D, flush_D, flush_E, stall_E, stall_M, flush_W}
   localparam logic [6:0] C_NONE = 7'b0000000;
   localparam logic [6:0] C_LD   = 7'b1101000;
   localparam logic [6:0] C_RDIR = 7'b0011000;
   localparam logic [6:0] C_MEM  = 7'b1100111;
   localparam logic [1:0] RUN = 2'd0, LDU = 2'd1, BRW = 2'd2, MEMW = 2'd3;
   localparam logic [1:0] WMEM = 2'b01, WALU = 2'b00;

   logic [6:0] ctrl_o;
   assign ctrl_o = {o_stall_F, o_stall_D, o_flush_D, o_flush_E, o_stall_E, o_stall_M, o_flush_W};

   int n_chk = 0;
   int n_pass = 0;

   typedef struct {
      logic [4:0] rs1, rs2;
      logic       u1, u2, br;
      logic [4:0] rdE;
      logic       wrE;
      logic [1:0] wbE;
      logic [4:0] rdM;
      logic       wrM, redir, busy;
      logic [6:0] exp_ctrl;
      logic [1:0] exp_nst;
   } vec_t;

   function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic br,
                               input logic [4:0] rdE, input logic wrE, input logic [1:0] wbE,
                               input logic [4:0] rdM, input logic wrM,
                               input logic redir, input logic busy,
                               input logic [6:0] ec, input logic [1:0] ns);
      vec_t v;
      v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.br = br;
      v.rdE = rdE; v.wrE = wrE; v.wbE = wbE; v.rdM = rdM; v.wrM = wrM;
      v.redir = redir; v.busy = busy; v.exp_ctrl = ec; v.exp_nst = ns;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic clear_in();
      i_rs1_addr_D = 0; i_rs2_addr_D = 0; i_rs1_used_D = 0; i_rs2_used_D = 0;
      i_is_branch_D = 0; i_rd_addr_E = 0; i_rd_wren_E = 0; i_wb_sel_E = WALU;
      i_rd_addr_M = 0; i_rd_wren_M = 0; i_redirect_E = 0; i_mem_busy_M = 0;
   endtask

   task automatic apply(input vec_t v);
      i_rs1_addr_D = v.rs1; i_rs2_addr_D = v.rs2; i_rs1_used_D = v.u1; i_rs2_used_D = v.u2;
      i_is_branch_D = v.br; i_rd_addr_E = v.rdE; i_rd_wren_E = v.wrE; i_wb_sel_E = v.wbE;
      i_rd_addr_M = v.rdM; i_rd_wren_M = v.wrM; i_redirect_E = v.redir; i_mem_busy_M = v.busy;
   endtask

   task automatic do_reset();
      clear_in();
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
   endtask

   vec_t vt[14];
   vec_t ld_br;
   int   nstall;

   initial begin
      //          rs1 rs2 u1 u2 br rdE wrE wbE  rdM wrM rd bz exp    next
      vt[0]  = mk(5,  1,  1, 1, 0, 5,  1,  WMEM, 0, 0,  0, 0, C_LD,   LDU);  // lw x5; add x6,x5,x1
      vt[1]  = mk(1,  5,  1, 1, 0, 5,  1,  WMEM, 0, 0,  0, 0, C_LD,   LDU);  // rs2 dependency
      vt[2]  = mk(0,  0,  1, 1, 0, 0,  1,  WMEM, 0, 0,  0, 0, C_NONE, RUN);  // lw x0
      vt[3]  = mk(5,  0,  1, 1, 1, 5,  1,  WMEM, 0, 0,  0, 0, C_LD,   BRW);  // lw x5; beq x5,x0
      vt[4]  = mk(7,  1,  1, 1, 1, 7,  1,  WALU, 0, 0,  0, 0, C_NONE, RUN);  // addi x7 in E; bne
      vt[5]  = mk(7,  1,  1, 1, 1, 0,  0,  WALU, 7, 1,  0, 0, C_LD,   BRW);  // addi x7 in M; bne
      vt[6]  = mk(7,  1,  1, 1, 0, 0,  0,  WALU, 7, 1,  0, 0, C_NONE, RUN);  // M dep, non-branch
      vt[7]  = mk(5,  5,  0, 0, 0, 5,  1,  WMEM, 0, 0,  0, 0, C_NONE, RUN);  // sources unused
      vt[8]  = mk(5,  1,  1, 1, 0, 5,  0,  WMEM, 0, 0,  0, 0, C_NONE, RUN);  // no write-enable
      vt[9]  = mk(0,  0,  0, 0, 0, 0,  0,  WALU, 0, 0,  1, 0, C_RDIR, RUN);  // redirect
      vt[10] = mk(0,  0,  0, 0, 0, 0,  0,  WALU, 0, 0,  0, 1, C_MEM,  MEMW); // mem busy
      vt[11] = mk(5,  1,  1, 1, 0, 5,  1,  WMEM, 0, 0,  1, 1, C_MEM,  MEMW); // busy beats all
      vt[12] = mk(5,  1,  1, 1, 0, 5,  1,  WMEM, 0, 0,  1, 0, C_RDIR, RUN);  // redirect beats ld
      vt[13] = mk(5,  5,  1, 1, 0, 5,  1,  WMEM, 0, 0,  0, 0, C_LD,   LDU);  // both rs match
      ld_br  = vt[3];

      clear_in();
      i_rst = 1'b1;
      #1;
      @(negedge i_clk);
      chk("reset_ctrl", 32'(ctrl_o), 32'(C_RDIR));
      tick();
      i_rst = 1'b0;
      #3;
      chk("reset_state", 32'(o_state), 32'(RUN));
      chk("post_reset_ctrl", 32'(ctrl_o), 32'(C_NONE));

      for (int i = 0; i < 14; i++) begin
         do_reset();
         apply(vt[i]);
         #3;
         chk($sformatf("vec%0d_ctrl", i), 32'(ctrl_o), 32'(vt[i].exp_ctrl));
         tick();
         clear_in();
         #3;
         chk($sformatf("vec%0d_state", i), 32'(o_state), 32'(vt[i].exp_nst));
      end

      // Load-use: one LDUSE cycle with no strobes, then back to RUN
      do_reset();
      apply(vt[0]); tick(); clear_in(); #3;
      chk("lu_ldu_ctrl", 32'(ctrl_o), 32'(C_NONE));
      tick(); #3;
      chk("lu_back_run", 32'(o_state), 32'(RUN));

      // Branch after load: exactly two consecutive stall cycles
      do_reset();
      apply(ld_br);
      nstall = 0;
      for (int c = 0; c < 5; c++) begin
         #3;
         if (o_stall_F && o_stall_D && o_flush_E) nstall++;
         if (c == 1) chk("ldbr_second_stall", 32'(ctrl_o), 32'(C_LD));
         tick();
         clear_in();
      end
      chk("ldbr_stall_count", 32'(nstall), 32'd2);
      chk("ldbr_final_state", 32'(o_state), 32'(RUN));

      // Branch after ALU producer in M: one stall cycle, then free
      do_reset();
      apply(vt[5]); tick(); clear_in(); #3;
      chk("mbr_brw_ctrl", 32'(ctrl_o), 32'(C_NONE));
      tick(); #3;
      chk("mbr_run", 32'(o_state), 32'(RUN));

      // Redirect in BRWAIT with cnt=1
      do_reset();
      apply(ld_br); tick(); clear_in();
      i_redirect_E = 1'b1; #3;
      chk("rdir_brw_state", 32'(o_state), 32'(BRW));
      chk("rdir_ctrl", 32'(ctrl_o), 32'(C_RDIR));
      tick(); clear_in(); #3;
      chk("rdir_next_state", 32'(o_state), 32'(RUN));
      chk("rdir_next_ctrl", 32'(ctrl_o), 32'(C_NONE));

      // Memory wait of 3 cycles inside BRWAIT cnt=1
      do_reset();
      apply(ld_br); tick(); clear_in();
      i_mem_busy_M = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #3;
         chk($sformatf("mw_busy%0d", c), 32'(ctrl_o), 32'(C_MEM));
         tick();
         chk($sformatf("mw_state%0d", c), 32'(o_state), 32'(MEMW));
      end
      i_mem_busy_M = 1'b0; #3;
      chk("mw_resume_stall", 32'(ctrl_o), 32'(C_LD));
      tick(); #3;
      chk("mw_brw_cnt0_ctrl", 32'(ctrl_o), 32'(C_NONE));
      chk("mw_brw_cnt0_state", 32'(o_state), 32'(BRW));
      tick(); #3;
      chk("mw_end_state", 32'(o_state), 32'(RUN));

      // Reset while in MEMWAIT
      do_reset();
      i_mem_busy_M = 1'b1; tick(); #3;
      chk("rst_mw_state", 32'(o_state), 32'(MEMW));
      i_rst = 1'b1; #1;
      chk("rst_mw_ctrl", 32'(ctrl_o), 32'(C_RDIR));
      tick(); i_rst = 1'b0; i_mem_busy_M = 1'b0; #3;
      chk("rst_mw_run", 32'(o_state), 32'(RUN));
      chk("rst_mw_quiet", 32'(ctrl_o), 32'(C_NONE));
`ifdef HAZARD_PERF_CNT_EN
      chk("rst_cnt_ld", o_cnt_ldstall, 32'd0);
      chk("rst_cnt_br", o_cnt_brstall, 32'd0);
      chk("rst_cnt_mem", o_cnt_memstall, 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core (F, D, E, M, W).
- Produces per-stage stall/flush strobes, including the decode-stage hold (`o_stall_D`) and the D/E bubble (`o_flush_E`).
- Covers load-use, decode-stage branch dependencies, E-stage redirects and data-memory wait.
- A small FSM with a down-counter sequences multi-cycle stalls, so hazard windows do not have to be re-derived every cycle.

Parameters:
- `WB_MEM`, 2'b01: `wb_sel` encoding meaning "result comes from data memory" (a load).
- `MAX_BR_WAIT`, 2: maximum branch-dependency stall cycles; counter width is `$clog2(MAX_BR_WAIT+1)`.

Ports:
- `i_clk`  in  1  clock, all state on the rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_rs1_addr_D`, `i_rs2_addr_D`  in  5 each  source registers of the instruction in D.
- `i_rs1_used_D`, `i_rs2_used_D`  in  1 each  the instruction in D actually reads that source.
- `i_is_branch_D`  in  1  the instruction in D is a conditional branch (compared in D).
- `i_rd_addr_E`, `i_rd_wren_E`, `i_wb_sel_E`  in  5/1/2  destination info of the instruction in E.
- `i_rd_addr_M`, `i_rd_wren_M`  in  5/1  destination info of the instruction in M.
- `i_redirect_E`  in  1  taken branch or jump resolved in E; the PC is redirected this cycle.
- `i_mem_busy_M`  in  1  data memory not ready; M must hold.
- `o_stall_F`  out  1  hold the PC.
- `o_stall_D`  out  1  hold the F/D register and the D/E enable path (D-stage hold).
- `o_flush_D`  out  1  clear the F/D register to a NOP.
- `o_flush_E`  out  1  clear the D/E register (bubble into E).
- `o_stall_E`, `o_stall_M`  out  1 each  hold the D/E and E/M registers.
- `o_flush_W`  out  1  bubble into the M/W register.
- `o_state`  out  2  current FSM state, for debug.

Behaviour:
- Hazard terms, where "match" means the address is equal, the corresponding `*_used_D` is set, and the address is nonzero:
  - `ld_E` = `i_rd_wren_E` & (`i_wb_sel_E`==`WB_MEM`) & rs match on `i_rd_addr_E`.
  - `alu_E_br` = `i_is_branch_D` & `i_rd_wren_E` & !`ld_E` & match on E. No stall is needed: the D-stage branch forwarding covers it.
  - `dep_M_br` = `i_is_branch_D` & `i_rd_wren_M` & match on `i_rd_addr_M`.
- FSM states: `S_RUN`, `S_LDUSE`, `S_BRWAIT`, `S_MEMWAIT`. A down-counter `cnt` holds the remaining stall cycles.
- Priority, highest first:
  1. reset
  2. `i_mem_busy_M`
  3. `i_redirect_E`
  4. active stall state
  5. new hazard
- `S_RUN`:
  - `ld_E` with a non-branch in D: stall F and D, `o_flush_E`=1 this cycle (Mealy output). Next state `S_LDUSE`, `cnt`=0.
  - `ld_E` with a branch in D: same outputs; next state `S_BRWAIT`, `cnt`=1. Total stall is 2 cycles.
  - `dep_M_br`: same outputs; next state `S_BRWAIT`, `cnt`=0. Total stall is 1 cycle.
- `S_LDUSE`: no outputs are asserted (the load has moved to M and forwarding resolves it). Returns to `S_RUN`. The state is retained so the stall cycle is visible for accounting.
- `S_BRWAIT`:
  - While `cnt`>0: stall F and D, flush E, decrement `cnt`.
  - At `cnt`==0: no stall; go to `S_RUN`.
  - No new hazard is evaluated while in `S_BRWAIT`.
- `i_redirect_E`, in any state other than `S_MEMWAIT`:
  - Outputs: `o_flush_D`=1, `o_flush_E`=1, all stalls 0.
  - FSM goes to `S_RUN` and `cnt`=0; any pending stall is abandoned because the stalled instruction is squashed.
- `i_mem_busy_M`, from any state:
  - Outputs: stall F, D, E and M; `o_flush_W`=1; all other flushes 0.
  - FSM goes to `S_MEMWAIT`. The previous state and `cnt` are saved and frozen.
  - When busy drops, restore the saved state and `cnt` and resume, with no lost or extra stall cycles.
  - A redirect arriving while busy is ignored by this block; the E/M register holds, so it is re-presented after the wait.
- Reset cycle:
  - Outputs: `o_flush_D`=1, `o_flush_E`=1, all others 0.
  - State: `S_RUN`, `cnt`=0, `o_state`=0.
- Register x0 never causes a hazard. A simultaneous rs1 and rs2 match counts as a single hazard.

Optional Feature:
- Macro: `HAZARD_PERF_CNT_EN`.
- When defined, three 32-bit saturating counters are added: `o_cnt_ldstall`, `o_cnt_brstall` and `o_cnt_memstall`.
  - Each increments once per cycle in which its stall cause drives `o_stall_F`.
  - All three clear on `i_rst` and saturate at 32'hFFFF_FFFF.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package `hazard_pkg`:
  - `state_e` enum covering the four states.
  - `WB_MEM` and the other `wb_sel` encodings.
  - Struct `hz_ctrl_t` bundling the seven stall/flush strobes.
- Sub-module `hazard_detect`: purely combinational; computes `ld_E`, `dep_M_br` and `alu_E_br`.
- `hazard_ctrl` holds the FSM, `cnt`, the save registers and the output muxing.

Test Plan:
- Load-use: `lw x5` in E with `add x6,x5,x1` in D → 1 cycle with `o_stall_F`=`o_stall_D`=`o_flush_E`=1, then all 0; `o_state` reads `S_LDUSE` for one cycle.
- Branch after load: `lw x5` in E with `beq x5,x0` in D → exactly 2 consecutive stall+flush_E cycles, then `S_RUN`.
- Branch after ALU op in M: `addi x7` in M with `bne x7,x1` in D → 1 stall cycle. The same producer in E as an ALU op → 0 stall cycles.
- Redirect mid-stall: in `S_BRWAIT` with `cnt`=1, assert `i_redirect_E` → that cycle `flush_D`=`flush_E`=1 with stalls 0; the next cycle is `S_RUN` with no stall.
- Memory wait inside a branch stall: `i_mem_busy_M` held 3 cycles during `S_BRWAIT` `cnt`=1 → 3 cycles with F/D/E/M stall and `flush_W`=1, then the remaining 1 branch-stall cycle exactly.
- x0 and reset: `lw x0` in E with `add` in D reading x0 → no stall. Asserting `i_rst` mid-`S_MEMWAIT` → next cycle `S_RUN` with counters (if enabled) at 0.
